// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types, constants and helpers for the sequential BCD converter
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD = 3;
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction
endpackage

// File: rtl/bin2bcd_seq_dig_adj.sv
// bcd_dig_adj: double-dabble per-digit correction, adds 3 to any digit of 5 or more
module bcd_dig_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= DIGIT_W'(ADJ_THRESH)) ? din + DIGIT_W'(ADJ_ADD) : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble binary-to-BCD converter, one shift per clock
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      out_sign,
  output logic                      out_ovf
);
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = cnt_w(BIN_W);
  state_t          state_q, state_d;
  logic [BIN_W-1:0] mag_q, mag_d;
  logic [BW-1:0]   dig_q, dig_d, adj, bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d, ovf_q, ovf_d, osign_q, osign_d, oovf_q, oovf_d;
  logic            neg;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_dig_adj u_adj (.din(dig_q[DIGIT_W*g +: DIGIT_W]), .dout(adj[DIGIT_W*g +: DIGIT_W]));
  end
  assign neg       = (SIGNED != 0) & in_bin[BIN_W-1];
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = state_q == DONE;
  assign out_bcd   = bcd_q;
  assign out_sign  = osign_q;
  assign out_ovf   = oovf_q;
  // next state: accept a word, run BIN_W adjust-and-shift steps, then hold the result
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    dig_d   = dig_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    osign_d = osign_q;
    oovf_d  = oovf_q;
    if (state_q == SHIFT) begin
      dig_d = {adj[BW-2:0], mag_q[BIN_W-1]};
      mag_d = mag_q << 1;
      ovf_d = ovf_q | adj[BW-1];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = DONE;
        bcd_d   = dig_d;
        osign_d = sign_q;
        oovf_d  = ovf_d;
      end
    end else if (in_valid && in_ready) begin
      state_d = SHIFT;
      mag_d   = neg ? -in_bin : in_bin;
      sign_d  = neg;
      dig_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = CW'(BIN_W);
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers; reset drops any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      osign_q <= 1'b0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      osign_q <= osign_d;
      oovf_q  <= oovf_d;
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed table plus corner sequences and a 16-bit scoreboard sweep
module tb_bin2bcd_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_bin = '0;
  logic rdy_u, ov_u, sg_u, of_u, rdy_s, ov_s, sg_s, of_s, rdy_d, ov_d, sg_d, of_d;
  logic [11:0] bcd_u, bcd_s;
  logic [7:0] bcd_d;
  logic iv16 = 1'b0, or16 = 1'b0, rdy16, ov16, sg16, of16;
  logic [15:0] ib16 = '0;
  logic [19:0] bcd16;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(0)) u_u (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rdy_u), .in_bin(in_bin), .out_valid(ov_u), .out_ready(out_ready), .out_bcd(bcd_u),
    .out_sign(sg_u), .out_ovf(of_u));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) u_s (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rdy_s), .in_bin(in_bin), .out_valid(ov_s), .out_ready(out_ready), .out_bcd(bcd_s),
    .out_sign(sg_s), .out_ovf(of_s));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2), .SIGNED(0)) u_d (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(rdy_d), .in_bin(in_bin), .out_valid(ov_d), .out_ready(out_ready), .out_bcd(bcd_d),
    .out_sign(sg_d), .out_ovf(of_d));
  bin2bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) u_w (.clk(clk), .rst_n(rst_n), .in_valid(iv16),
    .in_ready(rdy16), .in_bin(ib16), .out_valid(ov16), .out_ready(or16), .out_bcd(bcd16),
    .out_sign(sg16), .out_ovf(of16));

  typedef struct {
    logic [7:0]  in;
    logic [11:0] u;
    logic        s_sg;
    logic [11:0] s;
    logic [7:0]  d;
    logic        d_of;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] to_bcd(input int v, input int d);
    logic [39:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic start8(input logic [7:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_bin = v;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!ov_u && lat < 40);
  endtask

  task automatic release8();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] v16;
    tbl[0]  = '{8'd255, 12'h255, 1'b1, 12'h001, 8'h55, 1'b1};
    tbl[1]  = '{8'd0,   12'h000, 1'b0, 12'h000, 8'h00, 1'b0};
    tbl[2]  = '{8'h80,  12'h128, 1'b1, 12'h128, 8'h28, 1'b1};
    tbl[3]  = '{8'h7F,  12'h127, 1'b0, 12'h127, 8'h27, 1'b1};
    tbl[4]  = '{8'd100, 12'h100, 1'b0, 12'h100, 8'h00, 1'b1};
    tbl[5]  = '{8'd99,  12'h099, 1'b0, 12'h099, 8'h99, 1'b0};
    tbl[6]  = '{8'd42,  12'h042, 1'b0, 12'h042, 8'h42, 1'b0};
    tbl[7]  = '{8'd200, 12'h200, 1'b1, 12'h056, 8'h00, 1'b1};
    tbl[8]  = '{8'd9,   12'h009, 1'b0, 12'h009, 8'h09, 1'b0};
    tbl[9]  = '{8'd10,  12'h010, 1'b0, 12'h010, 8'h10, 1'b0};
    tbl[10] = '{8'd156, 12'h156, 1'b1, 12'h100, 8'h56, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 40'(ov_u), 40'd0);
    check("rst_bcd", 40'(bcd_u), 40'd0);
    check("rst_sign_ovf", 40'({sg_s, of_d}), 40'd0);
    check("rst_ready", 40'({rdy_u, rdy_s, rdy_d, rdy16}), 40'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      start8(tbl[i].in);
      wait8(lat);
      check($sformatf("lat[%0d]", i), 40'(lat), 40'd8);
      check($sformatf("valid_sd[%0d]", i), 40'({ov_s, ov_d}), 40'h3);
      check($sformatf("u_bcd[%0d]", i), 40'(bcd_u), 40'(tbl[i].u));
      check($sformatf("u_sg_of[%0d]", i), 40'({sg_u, of_u}), 40'd0);
      check($sformatf("s_bcd[%0d]", i), 40'(bcd_s), 40'(tbl[i].s));
      check($sformatf("s_sg_of[%0d]", i), 40'({sg_s, of_s}), 40'({tbl[i].s_sg, 1'b0}));
      check($sformatf("d_bcd[%0d]", i), 40'(bcd_d), 40'(tbl[i].d));
      check($sformatf("d_sg_of[%0d]", i), 40'({sg_d, of_d}), 40'({1'b0, tbl[i].d_of}));
      release8();
      check($sformatf("idle_ready[%0d]", i), 40'({ov_u, rdy_u}), 40'h1);
      check($sformatf("hold_bcd[%0d]", i), 40'(bcd_u), 40'(tbl[i].u));
    end
    start8(8'd255);
    wait8(lat);
    check("bp_lat", 40'(lat), 40'd8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_hold[%0d]", k), 40'({ov_u, rdy_u, rdy_s, rdy_d, bcd_u}), 40'({4'b1000, 12'h255}));
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bin = 8'd42;
    #1 check("bp_same_ready", 40'(rdy_u), 40'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b0;
    check("bp_shift", 40'({ov_u, rdy_u}), 40'd0);
    wait8(lat);
    check("bp_next_lat", 40'(lat + 1), 40'd8 + 40'd1);
    check("bp_next_bcd", 40'(bcd_u), 40'h042);
    release8();
    start8(8'd255);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out", 40'({ov_u, sg_s, of_d, bcd_u}), 40'd0);
    check("mid_rst_ready", 40'(rdy_u), 40'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst", 40'({ov_u, rdy_u}), 40'h1);
    start8(8'd200);
    wait8(lat);
    check("post_rst_lat", 40'(lat), 40'd8);
    check("post_rst_bcd", 40'(bcd_u), 40'h200);
    check("post_rst_d", 40'({of_d, bcd_d}), 40'h100);
    release8();
    for (int i = 0; i < 1000; i++) begin
      v16 = (i == 0) ? 16'd0 : (i == 1) ? 16'hFFFF : 16'($urandom_range(0, 65535));
      @(negedge clk);
      iv16 = 1'b1;
      ib16 = v16;
      @(posedge clk);
      #1 iv16 = 1'b0;
      lat = 0;
      do begin
        @(posedge clk);
        #1 lat++;
      end while (!ov16 && lat < 40);
      check($sformatf("w_lat[%0d]", i), 40'(lat), 40'd16);
      check($sformatf("w_bcd[%0d] in=%0d", i, v16), 40'(bcd16), to_bcd(int'(v16), 5));
      check($sformatf("w_sg_of[%0d]", i), 40'({sg16, of16}), 40'd0);
      @(negedge clk);
      or16 = 1'b1;
      @(posedge clk);
      #1 or16 = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
